// File: rtl/framebuffer_arbiter_if.sv
// Bus bundle between the framebuffer arbiter, its two requesters and the video RAM.
// The arbiter uses the slave modport; the surrounding system uses the master modport.
interface framebuffer_arbiter_if #(
    parameter int ADDR_WIDTH = 19
);
    logic                  wr_pixel_valid;
    logic [11:0]           wr_pixel_data;
    logic                  wr_address_load;
    logic [ADDR_WIDTH-1:0] wr_address;
    logic                  wr_fifo_full;
    logic                  wr_overflow;
    logic                  rd_request;
    logic [ADDR_WIDTH-1:0] rd_address;
    logic                  rd_grant;
    logic [11:0]           rd_data;
    logic                  rd_data_valid;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [11:0]           mem_write_data;
    logic                  mem_write_enable;
    logic                  mem_read_enable;
    logic [11:0]           mem_read_data;

    modport slave (
        input  wr_pixel_valid, wr_pixel_data, wr_address_load, wr_address,
        input  rd_request, rd_address, mem_read_data,
        output wr_fifo_full, wr_overflow, rd_grant, rd_data, rd_data_valid,
        output mem_address, mem_write_data, mem_write_enable, mem_read_enable
    );

    modport master (
        output wr_pixel_valid, wr_pixel_data, wr_address_load, wr_address,
        output rd_request, rd_address, mem_read_data,
        input  wr_fifo_full, wr_overflow, rd_grant, rd_data, rd_data_valid,
        input  mem_address, mem_write_data, mem_write_enable, mem_read_enable
    );
endinterface

// File: rtl/framebuffer_arbiter.sv
// Single-port framebuffer arbiter: display reads take priority, MCU pixel writes are
// cursor-tagged, queued in a small FIFO and issued in memory cycles left free by reads.
module framebuffer_arbiter #(
    parameter int ADDR_WIDTH   = 19,
    parameter int FRAME_PIXELS = 307200,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  system_clock,
    input  logic                  reset,
    framebuffer_arbiter_if.slave  bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_WIDTH + 12;
    localparam logic [ADDR_WIDTH-1:0] FRAME_LIMIT = ADDR_WIDTH'(FRAME_PIXELS);
    localparam logic [ADDR_WIDTH-1:0] LAST_PIXEL  = ADDR_WIDTH'(FRAME_PIXELS - 1);
    localparam logic [CNT_W-1:0]      FULL_COUNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} arb_state_t;

    arb_state_t            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] cursor_reg, cursor_next;
    logic [ADDR_WIDTH-1:0] load_value, pixel_address;
    logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]    fifo_head;
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop, drop;
    logic                  overflow_reg;
    logic [ADDR_WIDTH-1:0] mem_address_reg, mem_address_next;
    logic [11:0]           mem_write_data_reg, mem_write_data_next;
    logic                  read_pending_reg;
    logic                  rd_data_valid_reg;
    logic [11:0]           rd_data_reg;

    assign fifo_full  = (count_reg == FULL_COUNT);
    assign fifo_empty = (count_reg == '0);
    assign fifo_head  = fifo_mem[rd_ptr_reg];

    // Out-of-frame load values clamp to the first pixel.
    always_comb begin
        load_value    = (bus.wr_address >= FRAME_LIMIT) ? '0 : bus.wr_address;
        pixel_address = bus.wr_address_load ? load_value : cursor_reg;
        cursor_next   = cursor_reg;
        if (bus.wr_pixel_valid) begin
            cursor_next = (pixel_address == LAST_PIXEL) ? '0
                        : pixel_address + ADDR_WIDTH'(1);
        end else if (bus.wr_address_load) begin
            cursor_next = load_value;
        end
    end

    // A read may not directly follow a grant, so every other cycle stays open for writes.
    always_comb begin
        state_next          = ST_IDLE;
        mem_address_next    = mem_address_reg;
        mem_write_data_next = mem_write_data_reg;
        if (bus.rd_request && (state_reg != ST_READ)) begin
            state_next       = ST_READ;
            mem_address_next = bus.rd_address;
        end else if (!fifo_empty) begin
            state_next          = ST_WRITE;
            mem_address_next    = fifo_head[ENTRY_W-1:12];
            mem_write_data_next = fifo_head[11:0];
        end
    end

    always_comb begin
        pop  = (state_next == ST_WRITE);
        push = bus.wr_pixel_valid && (!fifo_full || pop);
        drop = bus.wr_pixel_valid && fifo_full && !pop;
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {pixel_address, bus.wr_pixel_data};
        end
    end

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            cursor_reg         <= '0;
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            count_reg          <= '0;
            overflow_reg       <= 1'b0;
            mem_address_reg    <= '0;
            mem_write_data_reg <= '0;
            read_pending_reg   <= 1'b0;
            rd_data_valid_reg  <= 1'b0;
            rd_data_reg        <= '0;
        end else begin
            state_reg          <= state_next;
            cursor_reg         <= cursor_next;
            count_reg          <= count_next;
            mem_address_reg    <= mem_address_next;
            mem_write_data_reg <= mem_write_data_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (drop) overflow_reg <= 1'b1;
            // RAM returns data one cycle after the strobe; capture it one cycle later.
            read_pending_reg  <= (state_reg == ST_READ);
            rd_data_valid_reg <= read_pending_reg;
            if (read_pending_reg) rd_data_reg <= bus.mem_read_data;
        end
    end

    assign bus.rd_grant         = (state_reg == ST_READ);
    assign bus.mem_read_enable  = (state_reg == ST_READ);
    assign bus.mem_write_enable = (state_reg == ST_WRITE);
    assign bus.mem_address      = mem_address_reg;
    assign bus.mem_write_data   = mem_write_data_reg;
    assign bus.rd_data          = rd_data_reg;
    assign bus.rd_data_valid    = rd_data_valid_reg;
    assign bus.wr_fifo_full     = fifo_full;
    assign bus.wr_overflow      = overflow_reg;
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter: a bus monitor logs memory traffic and every
// expectation below is hand-derived from the arbitration and cursor rules.
module tb_framebuffer_arbiter;
    localparam int AW = 19;

    logic system_clock = 1'b0;
    logic reset        = 1'b1;
    always #5 system_clock = ~system_clock;

    framebuffer_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    framebuffer_arbiter #(
        .ADDR_WIDTH  (AW),
        .FRAME_PIXELS(307200),
        .FIFO_DEPTH  (4)
    ) dut (
        .system_clock(system_clock),
        .reset       (reset),
        .bus         (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    int          wlog_addr[$];
    logic [11:0] wlog_data[$];
    int          wlog_cyc[$];
    int          grants = 0, grant_cyc = 0, rdv = 0, rdv_cyc = 0, overlaps = 0;
    logic [AW-1:0] grant_addr = '0;
    logic [11:0] rdv_data = '0;
    bit          full_seen = 1'b0;

    always @(posedge system_clock) cyc <= cyc + 1;

    function automatic logic [11:0] ram_value(input logic [AW-1:0] a);
        return (a == AW'(16)) ? 12'h5A5 : (a[11:0] ^ 12'h3C3);
    endfunction

    always @(posedge system_clock or posedge reset) begin
        if (reset) bus.mem_read_data <= '0;
        else if (bus.mem_read_enable) bus.mem_read_data <= ram_value(bus.mem_address);
    end

    always @(negedge system_clock) begin
        if (bus.mem_write_enable) begin
            wlog_addr.push_back(int'(bus.mem_address));
            wlog_data.push_back(bus.mem_write_data);
            wlog_cyc.push_back(cyc);
        end
        if (bus.mem_write_enable && bus.mem_read_enable) overlaps++;
        if (bus.rd_grant) begin
            grants++;
            grant_cyc  = cyc;
            grant_addr = bus.mem_address;
        end
        if (bus.rd_data_valid) begin
            rdv++;
            rdv_cyc  = cyc;
            rdv_data = bus.rd_data;
        end
        if (bus.wr_fifo_full) full_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic check_write(input string tag, input int idx, input int addr, input logic [11:0] data);
        if (idx < wlog_addr.size()) begin
            check({tag, "_addr"}, wlog_addr[idx], addr);
            check({tag, "_data"}, {20'h0, wlog_data[idx]}, {20'h0, data});
        end else begin
            check({tag, "_missing"}, wlog_addr.size(), idx + 1);
        end
    endtask

    task automatic tick;
        @(posedge system_clock);
        #1;
    endtask

    task automatic load(input int addr);
        bus.wr_address_load = 1'b1;
        bus.wr_address      = AW'(addr);
        tick();
        bus.wr_address_load = 1'b0;
    endtask

    task automatic push(input logic [11:0] data);
        bus.wr_pixel_valid = 1'b1;
        bus.wr_pixel_data  = data;
        tick();
        bus.wr_pixel_valid  = 1'b0;
        bus.wr_address_load = 1'b0;
    endtask

    initial begin
        int base, gb, rb, ov, t0;
        int ovf_addr[10];
        bus.wr_pixel_valid  = 1'b0;
        bus.wr_pixel_data   = '0;
        bus.wr_address_load = 1'b0;
        bus.wr_address      = '0;
        bus.rd_request      = 1'b0;
        bus.rd_address      = '0;
        ovf_addr = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 11};

        // Reset values
        repeat (3) tick();
        check("rst_grant", bus.rd_grant, 0);
        check("rst_rdv", bus.rd_data_valid, 0);
        check("rst_rdata", bus.rd_data, 0);
        check("rst_maddr", bus.mem_address, 0);
        check("rst_mwdata", bus.mem_write_data, 0);
        check("rst_we", bus.mem_write_enable, 0);
        check("rst_re", bus.mem_read_enable, 0);
        check("rst_full", bus.wr_fifo_full, 0);
        check("rst_ovf", bus.wr_overflow, 0);
        reset = 1'b0;
        repeat (2) tick();

        // Ordered writes from cursor 100
        base = wlog_addr.size();
        load(100);
        t0 = cyc;
        push(12'hABC);
        push(12'h123);
        push(12'hFFF);
        repeat (8) tick();
        check("ord_count", wlog_addr.size() - base, 3);
        check_write("ord0", base + 0, 100, 12'hABC);
        check_write("ord1", base + 1, 101, 12'h123);
        check_write("ord2", base + 2, 102, 12'hFFF);
        if (base < wlog_cyc.size()) check("ord_latency", wlog_cyc[base], t0 + 2);
        check("ord_ovf", bus.wr_overflow, 0);

        // Single read at 0x10
        gb = grants; rb = rdv;
        bus.rd_request = 1'b1;
        bus.rd_address = AW'(16);
        t0 = cyc;
        tick();
        tick();
        bus.rd_request = 1'b0;
        repeat (6) tick();
        check("rd_grants", grants - gb, 1);
        check("rd_grant_cyc", grant_cyc, t0 + 1);
        check("rd_grant_addr", grant_addr, 16);
        check("rd_valid_count", rdv - rb, 1);
        check("rd_data", rdv_data, 12'h5A5);
        check("rd_valid_cyc", rdv_cyc, t0 + 3);

        // Continuous read request with three queued pixels
        base = wlog_addr.size(); gb = grants; ov = overlaps;
        bus.rd_request = 1'b1;
        bus.rd_address = AW'(7);
        bus.wr_address_load = 1'b1;
        bus.wr_address = AW'(200);
        push(12'h111);
        push(12'h222);
        push(12'h333);
        repeat (7) tick();
        bus.rd_request = 1'b0;
        repeat (6) tick();
        check("cont_grants", grants - gb, 5);
        check("cont_writes", wlog_addr.size() - base, 3);
        check_write("cont0", base + 0, 200, 12'h111);
        check_write("cont1", base + 1, 201, 12'h222);
        check_write("cont2", base + 2, 202, 12'h333);
        check("cont_overlap", overlaps - ov, 0);

        // Overflow: 12 pixels against continuous reads
        check("pre_full_seen", full_seen, 0);
        base = wlog_addr.size();
        bus.rd_request = 1'b1;
        bus.rd_address = AW'(3);
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                bus.wr_address_load = 1'b1;
                bus.wr_address = '0;
            end
            push(12'(32'h100 + i));
        end
        repeat (4) tick();
        bus.rd_request = 1'b0;
        repeat (10) tick();
        check("ovf_sticky", bus.wr_overflow, 1);
        check("ovf_full_seen", full_seen, 1);
        check("ovf_writes", wlog_addr.size() - base, 10);
        for (int k = 0; k < 10; k++) begin
            check_write($sformatf("ovf%0d", k), base + k, ovf_addr[k],
                        12'(32'h100 + ovf_addr[k]));
        end
        push(12'h1FF);
        repeat (6) tick();
        check_write("ovf_cursor", base + 10, 12, 12'h1FF);

        // Frame wrap, clamp, and load coinciding with a pixel
        base = wlog_addr.size();
        load(307199);
        push(12'h0A1);
        push(12'h0A2);
        repeat (6) tick();
        check_write("wrap_last", base + 0, 307199, 12'h0A1);
        check_write("wrap_zero", base + 1, 0, 12'h0A2);
        base = wlog_addr.size();
        load(400000);
        push(12'h0B1);
        repeat (6) tick();
        check_write("clamp", base, 0, 12'h0B1);
        base = wlog_addr.size();
        bus.wr_address_load = 1'b1;
        bus.wr_address = AW'(50);
        push(12'h0C1);
        push(12'h0C2);
        repeat (6) tick();
        check_write("ldpix0", base + 0, 50, 12'h0C1);
        check_write("ldpix1", base + 1, 51, 12'h0C2);

        // Reset with a read in flight and a write queued
        base = wlog_addr.size(); rb = rdv;
        bus.rd_request = 1'b1;
        bus.rd_address = AW'(16);
        push(12'hDD1);
        bus.rd_request = 1'b0;
        check("mid_grant_before", bus.rd_grant, 1);
        reset = 1'b1;
        #1;
        check("mid_grant", bus.rd_grant, 0);
        check("mid_re", bus.mem_read_enable, 0);
        check("mid_we", bus.mem_write_enable, 0);
        check("mid_maddr", bus.mem_address, 0);
        check("mid_ovf", bus.wr_overflow, 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (8) tick();
        check("mid_no_writes", wlog_addr.size() - base, 0);
        check("mid_no_rdv", rdv - rb, 0);
        check("mid_full", bus.wr_fifo_full, 0);
        check("all_overlap", overlaps, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/framebuffer_arbiter.md
# framebuffer_arbiter

Shares the single-port framebuffer RAM between two requesters: the MCU pixel write stream (12-bit pixels assembled from the MCU bus) and the display scanout read port. Incoming pixels are tagged with an auto-incrementing write cursor and buffered in a small FIFO. Pending writes are issued only in memory cycles not claimed by the display, which always has priority. The block sits in the `system_clock` domain between the message broker and the video RAM.

## Interface
- `ADDR_WIDTH`, 19, framebuffer address width
- `FRAME_PIXELS`, 307200, pixels per frame (640x480); cursor wrap point
- `FIFO_DEPTH`, 4, write FIFO entries; power of two, ≥2
- `system_clock`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high
- `wr_pixel_valid`  in  1  one-cycle strobe, pixel present (already synchronous to `system_clock`)
- `wr_pixel_data`  in  12  pixel value, RGB444
- `wr_address_load`  in  1  one-cycle strobe, load write cursor
- `wr_address`  in  ADDR_WIDTH  new cursor value
- `wr_fifo_full`  out  1  FIFO holds FIFO_DEPTH entries
- `wr_overflow`  out  1  sticky, pixel dropped since reset
- `rd_request`  in  1  display read request, held until `rd_grant`
- `rd_address`  in  ADDR_WIDTH  read address, stable while `rd_request` high
- `rd_grant`  out  1  one-cycle, read issued this cycle
- `rd_data`  out  12  read result
- `rd_data_valid`  out  1  one-cycle, `rd_data` valid
- `mem_address`  out  ADDR_WIDTH  RAM address
- `mem_write_data`  out  12  RAM write data
- `mem_write_enable`  out  1  RAM write strobe
- `mem_read_enable`  out  1  RAM read strobe
- `mem_read_data`  in  12  RAM read data, valid the cycle after `mem_read_enable`

## Operation
- Write cursor (ADDR_WIDTH bits) is the address given to each accepted pixel.
- On `wr_address_load`, the cursor becomes `wr_address`. Values ≥ FRAME_PIXELS load as 0.
- On `wr_pixel_valid`, the pixel is tagged with the current cursor, or with the loaded value if `wr_address_load` is in the same cycle. The cursor then increments.
- Cursor increment wraps from FRAME_PIXELS-1 to 0.
- FIFO entry = {address, pixel}. Push happens when `wr_pixel_valid` is high and the FIFO is not full.
- Push while full drops the pixel and sets `wr_overflow`. The cursor still increments, so screen geometry is preserved. `wr_overflow` clears only on reset.
- If push and pop occur on the same edge while full, the push is accepted and there is no overflow.
- Arbitration decision is made each edge, with outputs registered. There are three outcomes:
  - READ: when `rd_request`=1 and `rd_grant`=0. Drives `rd_grant`=1, `mem_read_enable`=1, `mem_address`=`rd_address`.
  - WRITE: otherwise, when the FIFO is non-empty. Pops the FIFO head and drives `mem_write_enable`=1, `mem_address`/`mem_write_data` from the head.
  - IDLE: otherwise. Both enables are 0; `mem_address` and `mem_write_data` hold.
- `rd_request` is ignored in any cycle where `rd_grant` is high, so one request yields exactly one grant. Maximum read rate is one per two cycles, which leaves every other cycle free for writes.
- `mem_read_enable` and `mem_write_enable` are never high together.
- Read pipeline: `mem_read_data` is captured the cycle after `mem_read_enable` into `rd_data`, with `rd_data_valid` pulsed.

## Timing
- Reset values: every output 0, FIFO empty, cursor 0, `wr_overflow` 0.
- Reset mid-operation: queued writes are discarded, an in-flight read returns no `rd_data_valid`, and no memory strobe is asserted while `reset` is high.
- Read latency:
  - `rd_request` sampled at edge E gives `rd_grant`/`mem_read_enable` in cycle E+1.
  - `mem_read_data` is valid in cycle E+2.
  - `rd_data_valid` and `rd_data` appear in cycle E+3, i.e. two cycles after `rd_grant`.
- Write latency with no read contention: `wr_pixel_valid` at edge E gives FIFO count 1 after E and `mem_write_enable` in cycle E+2.
- `wr_fifo_full` is decoded from the registered count and is valid the cycle after the count changes.
- FIFO pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.

## Test plan
- Reset: assert `reset` during an active read and pending writes → all outputs 0 immediately; after release, no `rd_data_valid` and no writes until new stimulus.
- Ordered writes: load cursor 100, push 0xABC, 0x123, 0xFFF on consecutive cycles, no reads → three `mem_write_enable` pulses, at addresses 100/101/102 with data in order.
- Read path: `rd_request` at 0x00010, RAM model returns 0x5A5 → a single one-cycle `rd_grant` with `mem_address`=0x00010; `rd_data`=0x5A5 with `rd_data_valid` two cycles after the grant; no second grant while the request is held through the grant cycle.
- Contention: hold `rd_request` high continuously with 3 queued pixels → READ/WRITE alternate, all 3 writes complete, enables never overlap.
- Overflow: hold `rd_request` high, push 12 pixels on consecutive cycles from cursor 0 (FIFO_DEPTH=4) → `wr_fifo_full` asserts and `wr_overflow` sets. Accepted pixels are written at their original cursor addresses; dropped pixels are never written; the cursor ends at 12.
- Wrap/clamp:
  - Load 307199, push 2 pixels → writes at 307199 then 0.
  - Load 400000, push 1 pixel → write at 0.
  - `wr_address_load` with `wr_pixel_valid` in the same cycle, value 50 → pixel at 50, next pixel at 51.
